rom_stream_reader: RTL

//  Drives the address port of the single-port block ROM (1-cycle registered read) and

---
 rtl/rom_stream_reader_if.sv | 31 +++
 rtl/rom_stream_reader.sv | 138 +++++++++++++
 2 files changed

// File: rtl/rom_stream_reader_if.sv
// rom_stream_reader_if: bundles the control, ROM and stream signals of rom_stream_reader.
//   Control: start, base_addr, len (in) / busy, done (out)
//   ROM:     rom_addr (out) / rom_data (in)
//   Stream:  m_data, m_valid, m_last (out) / m_ready (in)
// modport master is the reader side; modport slave is the side that talks to it.
interface rom_stream_reader_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (
    input  start, base_addr, len, rom_data, m_ready,
    output busy, done, rom_addr, m_data, m_valid, m_last
  );

  modport slave (
    output start, base_addr, len, rom_data, m_ready,
    input  busy, done, rom_addr, m_data, m_valid, m_last
  );
endinterface

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: reads len words from a registered-read block ROM starting at base_addr
// and presents them as a valid/ready stream with m_last on the final word.
//   sysclk : clock, rising edge
//   rst    : asynchronous active-high reset
//   bus    : rom_stream_reader_if.master (start/base_addr/len, busy/done, rom_addr/rom_data,
//            m_data/m_valid/m_ready/m_last)
// Addresses are only issued while the output FIFO has room for every read already in
// flight, so back-pressure can never overflow the buffer.
module rom_stream_reader #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ROM_LAT    = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 sysclk,
  input  logic                 rst,
  rom_stream_reader_if.master  bus
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {StIdle, StRun, StDrain, StZero, StDone} state_e;

  state_e            r_state, w_state_next;
  logic [ADDR_W:0]   r_remain;     // addresses still to issue
  logic [ADDR_W-1:0] r_rom_addr;
  // Stage 0 marks "rom_addr carries a fresh read"; stage ROM_LAT marks "rom_data is ours".
  logic [ROM_LAT:0]  r_tag;
  logic [ROM_LAT:0]  r_tag_last;
  logic [DATA_W:0]   r_mem [FIFO_DEPTH];  // {last, data}
  logic [PtrW-1:0]   r_wptr, r_rptr;
  logic [CntW-1:0]   r_count;

  logic        w_start_ok, w_issue, w_issue_last, w_credit;
  logic        w_wr, w_rd, w_valid, w_head_last;
  int unsigned w_inflight;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    w_inflight = 0;
    for (int i = 0; i <= int'(ROM_LAT); i++) begin
      if (r_tag[i]) w_inflight++;
    end
  end

  assign w_credit     = (32'(r_count) + w_inflight) < FIFO_DEPTH;
  assign w_start_ok   = (r_state == StIdle) && bus.start;
  assign w_issue      = (w_start_ok && (bus.len != '0)) ||
                        ((r_state == StRun) && (r_remain != '0) && w_credit);
  assign w_issue_last = (r_state == StIdle) ? (bus.len == (ADDR_W+1)'(1))
                                            : (r_remain == (ADDR_W+1)'(1));
  assign w_valid      = (r_count != '0);
  assign w_wr         = r_tag[ROM_LAT];
  assign w_rd         = w_valid && bus.m_ready;
  assign w_head_last  = r_mem[r_rptr][DATA_W];

  // State register
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (bus.start) w_state_next = (bus.len == '0) ? StZero : StRun;
      StRun:   if (r_remain == '0) w_state_next = StDrain;
      StDrain: if (w_rd && w_head_last) w_state_next = StDone;
      StZero:  w_state_next = StIdle;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs: a zero-length request shows busy and done together for its single cycle.
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (r_state)
      StRun, StDrain: bus.busy = 1'b1;
      StZero: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      StDone:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // Address issue, tag pipeline and output FIFO
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_remain   <= '0;
      r_rom_addr <= '0;
      r_tag      <= '0;
      r_tag_last <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (w_issue) begin
        r_rom_addr <= (r_state == StIdle) ? bus.base_addr : r_rom_addr + ADDR_W'(1);
      end
      if (w_start_ok) begin
        r_remain <= (bus.len == '0) ? '0 : bus.len - (ADDR_W+1)'(1);
      end else if (w_issue) begin
        r_remain <= r_remain - (ADDR_W+1)'(1);
      end
      r_tag      <= {r_tag[ROM_LAT-1:0], w_issue};
      r_tag_last <= {r_tag_last[ROM_LAT-1:0], w_issue && w_issue_last};
      if (w_wr) begin
        r_mem[r_wptr] <= {r_tag_last[ROM_LAT], bus.rom_data};
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (w_rd) r_rptr <= ptr_inc(r_rptr);
      if (w_wr && !w_rd)      r_count <= r_count + CntW'(1);
      else if (!w_wr && w_rd) r_count <= r_count - CntW'(1);
    end
  end

  assign bus.rom_addr = r_rom_addr;
  assign bus.m_valid  = w_valid;
  assign bus.m_data   = w_valid ? r_mem[r_rptr][DATA_W-1:0] : '0;
  assign bus.m_last   = w_valid && w_head_last;

`ifndef SYNTHESIS
  // The credit rule must make a write into a full, non-draining FIFO impossible.
  a_no_overflow: assert property (@(posedge sysclk) disable iff (rst)
    !(w_wr && !w_rd && (r_count == CntW'(FIFO_DEPTH))));
`endif

endmodule
